ber_test_ctrl: RTL and testbench
================================

BER_TEST_CTRL -- requirements
Module: ber_test_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_TIMEOUT, default 1024, meaning the maximum cycles spent in SYNC waiting for sync.
REQ-002 The block SHALL have parameter NUM_WIN, default 16, meaning the number of counted measurement windows per test (1..31).
REQ-003 The block SHALL have parameter ACC_W, default 16, meaning the width of the error accumulator.
REQ-004 Port clk_390p625M, input, 1: system clock, rising-edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: one-cycle request to begin a test.
REQ-007 Port abort, input, 1: level request to terminate the test in progress.
REQ-008 Port threshold, input, ACC_W: maximum total errors for a pass, sampled on the accepted start.
REQ-009 Port mon_sync_ready, input, 1: sync indication from the BER monitor.
REQ-010 Port mon_err_count, input, 10: per-window error count from the monitor.
REQ-011 Port mon_win_done, input, 1: one-cycle strobe; mon_err_count is valid for the window that just closed.
REQ-012 Port mon_en, output, 1: enable to the BER monitor.
REQ-013 Port busy, output, 1: test in progress.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port pass, output, 1: test verdict.
REQ-016 Port sync_fail, output, 1: sync timeout or loss of sync occurred.
REQ-017 Port err_total, output, ACC_W: accumulated errors.
REQ-018 Port win_count, output, 5: number of windows accumulated.

Function
REQ-019 The FSM SHALL have states IDLE, SYNC, MEASURE and FINISH, and all outputs SHALL be registered.
REQ-020 IDLE: mon_en=0 and busy=0.
  - start=1 and abort=0 -> SYNC.
  - On that edge: clear err_total, win_count, pass, sync_fail and the timer; latch threshold; set the discard flag.
REQ-021 SYNC: mon_en=1, busy=1, and the timer increments each cycle.
  - mon_sync_ready=1 -> MEASURE.
  - Otherwise, timer == SYNC_TIMEOUT-1 -> FINISH with sync_fail=1.
REQ-022 MEASURE: mon_en=1 and busy=1.
  - First mon_win_done after entry: clear the discard flag only. That window spans pre-sync cycles and is not counted.
  - Each later mon_win_done: err_total += mon_err_count (zero-extended), and win_count += 1.
REQ-023 err_total SHALL saturate at 2^ACC_W-1 and never wrap.
REQ-024 MEASURE SHALL go to FINISH on the edge where win_count becomes NUM_WIN.
REQ-025 MEASURE with mon_sync_ready=0 SHALL go to FINISH with sync_fail=1; a same-cycle mon_win_done SHALL NOT be accumulated.
REQ-026 FINISH SHALL last exactly one cycle, with mon_en=0, busy=1 and done=1, then go to IDLE.
REQ-027 pass SHALL be set on the edge entering FINISH to (!sync_fail_next && err_total_next <= threshold_latched).
  - _next denotes the values being loaded on that same edge.
  - pass, sync_fail, err_total and win_count SHALL hold until the next accepted start.
REQ-028 done SHALL rise exactly one cycle after the terminating event (final strobe, timeout cycle, or sync-loss cycle).
REQ-029 abort=1 in SYNC, MEASURE or FINISH SHALL force IDLE on the next edge.
  - mon_en=0, done=0, pass=0.
  - err_total and win_count hold.
REQ-030 abort SHALL take priority over every other transition.
REQ-031 start while busy=1 SHALL be ignored; start and abort together in IDLE SHALL stay in IDLE.
REQ-032 mon_err_count and mon_win_done SHALL be ignored outside MEASURE.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE and set mon_en, busy, done, pass, sync_fail, err_total, win_count, the timer and the discard flag to 0.
REQ-034 Reset asserted mid-test SHALL abandon the test with no done pulse; start is honoured from the first edge after deassertion.

Verification (NUM_WIN=4, SYNC_TIMEOUT=8, ACC_W=16)
REQ-035 Nominal:
  - Stimulus: threshold=10, start; sync after 3 cycles; 5 strobes with counts 7,2,3,1,4.
  - Response: first window (7) discarded; err_total=10, win_count=4, pass=1, sync_fail=0, done one cycle after the 5th strobe.
REQ-036 Threshold exceeded:
  - Stimulus: threshold=9, same traffic as REQ-035.
  - Response: err_total=10, pass=0.
REQ-037 Timeout:
  - Stimulus: start; mon_sync_ready held 0.
  - Response: mon_en high 8 cycles; done on the 9th cycle after SYNC entry; sync_fail=1, pass=0, win_count=0.
REQ-038 Sync loss:
  - Stimulus: sync, 2 counted strobes (count 5 each), then mon_sync_ready=0 in the same cycle as a strobe with count 9.
  - Response: err_total=10, win_count=2, sync_fail=1, pass=0.
REQ-039 Saturation and abort:
  - Stimulus: ACC_W=8, strobes of count 200 and 200.
  - Response: err_total=255.
  - Stimulus: abort in MEASURE.
  - Response: IDLE next edge, no done pulse, mon_en=0.
REQ-040 Reset mid-MEASURE and start-while-busy:
  - Stimulus: rst_n=0 in MEASURE.
  - Response: all outputs 0 immediately, no done pulse.
  - Stimulus: start pulsed in SYNC.
  - Response: no restart and no effect on err_total.

Source files
------------

// File: rtl/ber_test_ctrl.sv
// BER test sequencer: enables the BER monitor, waits for sync, accumulates
// per-window error counts over NUM_WIN windows and reports a pass/fail verdict.
module ber_test_ctrl #(
  parameter int unsigned SYNC_TIMEOUT = 1024,
  parameter int unsigned NUM_WIN      = 16,
  parameter int unsigned ACC_W        = 16
) (
  input  logic             clk_390p625M,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ACC_W-1:0] threshold,
  input  logic             mon_sync_ready,
  input  logic [9:0]       mon_err_count,
  input  logic             mon_win_done,
  output logic             mon_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             sync_fail,
  output logic [ACC_W-1:0] err_total,
  output logic [4:0]       win_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SYNC    = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  localparam int unsigned TW    = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam int unsigned SUM_W = ((ACC_W > 10) ? ACC_W : 10) + 1;

  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic             discard;
  logic [ACC_W-1:0] thr_q;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_next;
  logic [4:0]       win_next;

  // Saturating add: any carry beyond ACC_W bits clamps to all-ones.
  always_comb begin
    sum      = SUM_W'(err_total) + SUM_W'(mon_err_count);
    acc_next = (|(sum >> ACC_W)) ? '1 : sum[ACC_W-1:0];
    win_next = win_count + 5'd1;
  end

  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mon_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      sync_fail <= 1'b0;
      err_total <= '0;
      win_count <= '0;
      timer     <= '0;
      discard   <= 1'b0;
      thr_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state     <= S_SYNC;
            mon_en    <= 1'b1;
            busy      <= 1'b1;
            pass      <= 1'b0;
            sync_fail <= 1'b0;
            err_total <= '0;
            win_count <= '0;
            timer     <= '0;
            discard   <= 1'b1;
            thr_q     <= threshold;
          end
        end
        S_SYNC: begin
          timer <= timer + 1'b1;
          if (abort) begin
            state  <= S_IDLE;
            mon_en <= 1'b0;
            busy   <= 1'b0;
            pass   <= 1'b0;
          end else if (mon_sync_ready) begin
            state <= S_MEASURE;
          end else if (timer == TW'(SYNC_TIMEOUT - 1)) begin
            state     <= S_FINISH;
            mon_en    <= 1'b0;
            done      <= 1'b1;
            sync_fail <= 1'b1;
            pass      <= 1'b0;
          end
        end
        S_MEASURE: begin
          if (abort) begin
            state  <= S_IDLE;
            mon_en <= 1'b0;
            busy   <= 1'b0;
            pass   <= 1'b0;
          end else if (!mon_sync_ready) begin
            state     <= S_FINISH;
            mon_en    <= 1'b0;
            done      <= 1'b1;
            sync_fail <= 1'b1;
            pass      <= 1'b0;
          end else if (mon_win_done) begin
            // The first window after sync straddles pre-sync traffic.
            if (discard) begin
              discard <= 1'b0;
            end else begin
              err_total <= acc_next;
              win_count <= win_next;
              if (win_next == 5'(NUM_WIN)) begin
                state  <= S_FINISH;
                mon_en <= 1'b0;
                done   <= 1'b1;
                pass   <= (acc_next <= thr_q);
              end
            end
          end
        end
        S_FINISH: begin
          state  <= S_IDLE;
          mon_en <= 1'b0;
          busy   <= 1'b0;
          if (abort) pass <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          mon_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Directed bench for ber_test_ctrl (NUM_WIN=4, SYNC_TIMEOUT=8); a second
// ACC_W=8 instance shares the stimulus to observe saturation.
module tb_ber_test_ctrl;

  logic        clk_390p625M = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] threshold;
  logic        mon_sync_ready, mon_win_done;
  logic [9:0]  mon_err_count;

  logic        mon_en, busy, done, pass, sync_fail;
  logic [15:0] err_total;
  logic [4:0]  win_count;
  logic        mon_en8, busy8, done8, pass8, sync_fail8;
  logic [7:0]  err_total8;
  logic [4:0]  win_count8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk_390p625M = ~clk_390p625M;

  ber_test_ctrl #(.SYNC_TIMEOUT(8), .NUM_WIN(4), .ACC_W(16)) dut (
    .clk_390p625M(clk_390p625M), .rst_n(rst_n), .start(start), .abort(abort),
    .threshold(threshold), .mon_sync_ready(mon_sync_ready),
    .mon_err_count(mon_err_count), .mon_win_done(mon_win_done),
    .mon_en(mon_en), .busy(busy), .done(done), .pass(pass),
    .sync_fail(sync_fail), .err_total(err_total), .win_count(win_count)
  );

  ber_test_ctrl #(.SYNC_TIMEOUT(8), .NUM_WIN(4), .ACC_W(8)) dut8 (
    .clk_390p625M(clk_390p625M), .rst_n(rst_n), .start(start), .abort(abort),
    .threshold(threshold[7:0]), .mon_sync_ready(mon_sync_ready),
    .mon_err_count(mon_err_count), .mon_win_done(mon_win_done),
    .mon_en(mon_en8), .busy(busy8), .done(done8), .pass(pass8),
    .sync_fail(sync_fail8), .err_total(err_total8), .win_count(win_count8)
  );

  typedef struct packed {
    logic [15:0]     thr;
    logic [4:0][9:0] cnt;
    logic [2:0]      n;
    logic [2:0]      delay;
    logic [2:0]      drop;   // strobe index that coincides with sync loss, 7 = none
    logic [15:0]     e_tot;
    logic [4:0]      e_win;
    logic            e_pass;
    logic            e_sf;
    logic [7:0]      e_tot8;
  } scn_t;

  scn_t tbl[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_390p625M);
    #1;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    string tag;
    tag = $sformatf("scn%0d", idx);
    threshold = s.thr;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_sync"}, busy, 1);
    chk({tag, "_en_sync"}, mon_en, 1);
    mon_sync_ready = 1'b0;
    for (int d = 0; d < int'(s.delay); d++) tick();
    mon_sync_ready = 1'b1;
    for (int i = 0; i < int'(s.n); i++) begin
      tick();
      mon_win_done  = 1'b1;
      mon_err_count = s.cnt[i];
      if (i == int'(s.drop)) mon_sync_ready = 1'b0;
      tick();
      mon_win_done  = 1'b0;
      mon_err_count = '0;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err_total"}, err_total, s.e_tot);
    chk({tag, "_win_count"}, win_count, s.e_win);
    chk({tag, "_pass"}, pass, s.e_pass);
    chk({tag, "_sync_fail"}, sync_fail, s.e_sf);
    chk({tag, "_err_total8"}, err_total8, s.e_tot8);
    mon_sync_ready = 1'b0;
    tick();
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold_total"}, err_total, s.e_tot);
  endtask

  initial begin
    int en_cycles;
    int done_at;

    tbl[0] = '{thr: 16'd10, cnt: {10'd4, 10'd1, 10'd3, 10'd2, 10'd7}, n: 3'd5, delay: 3'd3,
               drop: 3'd7, e_tot: 16'd10, e_win: 5'd4, e_pass: 1'b1, e_sf: 1'b0, e_tot8: 8'd10};
    tbl[1] = '{thr: 16'd9, cnt: {10'd4, 10'd1, 10'd3, 10'd2, 10'd7}, n: 3'd5, delay: 3'd3,
               drop: 3'd7, e_tot: 16'd10, e_win: 5'd4, e_pass: 1'b0, e_sf: 1'b0, e_tot8: 8'd10};
    tbl[2] = '{thr: 16'd100, cnt: {10'd0, 10'd9, 10'd5, 10'd5, 10'd3}, n: 3'd4, delay: 3'd1,
               drop: 3'd3, e_tot: 16'd10, e_win: 5'd2, e_pass: 1'b0, e_sf: 1'b1, e_tot8: 8'd10};
    tbl[3] = '{thr: 16'd300, cnt: {10'd0, 10'd0, 10'd200, 10'd200, 10'd1}, n: 3'd5, delay: 3'd1,
               drop: 3'd7, e_tot: 16'd400, e_win: 5'd4, e_pass: 1'b0, e_sf: 1'b0, e_tot8: 8'd255};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; threshold = '0;
    mon_sync_ready = 1'b0; mon_win_done = 1'b0; mon_err_count = '0;
    #12;
    chk("rst_mon_en", mon_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sync_fail", sync_fail, 0);
    chk("rst_err_total", err_total, 0);
    chk("rst_win_count", win_count, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_scn(i, tbl[i]);

    // Timeout, with a start pulse in SYNC that must not restart the timer.
    start = 1'b1;
    tick();
    start = 1'b0;
    en_cycles = 0;
    done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      if (mon_en) en_cycles++;
      if (done) begin
        done_at = k;
        break;
      end
      start = (k == 3);
      tick();
    end
    start = 1'b0;
    chk("to_en_cycles", en_cycles, 8);
    chk("to_done_at", done_at, 9);
    chk("to_sync_fail", sync_fail, 1);
    chk("to_pass", pass, 0);
    chk("to_win_count", win_count, 0);
    tick();
    chk("to_idle", busy, 0);

    // Abort in MEASURE, start while busy, ignored inputs in IDLE.
    threshold = 16'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    mon_sync_ready = 1'b1;
    tick();
    mon_win_done = 1'b1; mon_err_count = 10'd1;
    tick();
    mon_err_count = 10'd5;
    tick();
    mon_win_done = 1'b0; mon_err_count = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("swb_busy", busy, 1);
    chk("swb_err_total", err_total, 5);
    chk("swb_win_count", win_count, 1);
    abort = 1'b1;
    tick();
    chk("ab_busy", busy, 0);
    chk("ab_mon_en", mon_en, 0);
    chk("ab_done", done, 0);
    chk("ab_pass", pass, 0);
    chk("ab_err_total", err_total, 5);
    chk("ab_win_count", win_count, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_abort_idle", busy, 0);
    abort = 1'b0;
    mon_win_done = 1'b1; mon_err_count = 10'd9;
    tick();
    mon_win_done = 1'b0; mon_err_count = '0;
    chk("idle_ignore_strobe", err_total, 5);
    chk("ab_no_done", done, 0);

    // Asynchronous reset mid-MEASURE.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mon_win_done = 1'b1; mon_err_count = 10'd2;
    tick();
    mon_err_count = 10'd5;
    tick();
    mon_win_done = 1'b0; mon_err_count = '0;
    chk("pre_rst_err_total", err_total, 5);
    rst_n = 1'b0;
    #1;
    chk("mrst_mon_en", mon_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err_total", err_total, 0);
    chk("mrst_win_count", win_count, 0);
    chk("mrst_pass_sf", {pass, sync_fail, done}, 0);
    #3;
    rst_n = 1'b1;
    mon_sync_ready = 1'b0;
    tick();
    chk("mrst_no_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mrst_restart", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
